// File: rtl/umi_data_splitter.sv
`default_nettype none
// ============================================================================
// Module   : umi_data_splitter
// Purpose  : Splits write / posted-write / read-response UMI flits whose
//            payload exceeds SPLIT_BYTES into several smaller flits with
//            adjusted len, dstaddr, data and eom. All other flits pass
//            through unchanged. One flit is held at a time; the next flit can
//            be accepted in the cycle its last piece is handshaken.
// Ports    : clk, reset (async, active high)
//            umi_in_*  : input UMI flit (valid/ready handshake)
//            umi_out_* : output UMI flit, fully registered
// Revision : 1.0 - initial release
// ============================================================================
module umi_data_splitter #(
  parameter int CW          = 32,
  parameter int AW          = 64,
  parameter int DW          = 64,
  parameter int SPLIT_BYTES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          umi_in_valid,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_out_ready
);

  localparam int NB = DW / 8;
  localparam int BW = $clog2(NB) + 2;  // byte-count width
  localparam int OW = $clog2(NB) + 1;  // offset-counter width

  // UMI opcodes eligible for splitting
  localparam logic [4:0] OP_RESP_READ  = 5'h02;
  localparam logic [4:0] OP_REQ_WRITE  = 5'h03;
  localparam logic [4:0] OP_REQ_POSTED = 5'h05;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] data_q, data_d;
  logic [BW-1:0] bytes_q, bytes_d;
  logic          split_q, split_d;
  logic [OW-1:0] off_q, off_d;

  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_cmd_q, out_cmd_d;
  logic [AW-1:0] out_dst_q, out_dst_d;
  logic [AW-1:0] out_src_q, out_src_d;
  logic [DW-1:0] out_data_q, out_data_d;

  // Incoming flit decode
  logic [15:0]   in_full;
  logic [BW-1:0] in_bytes;
  logic          in_opc_ok;
  logic          in_split;

  always_comb begin
    in_full   = ({8'd0, umi_in_cmd[15:8]} + 16'd1) << umi_in_cmd[7:5];
    in_bytes  = (in_full > 16'(NB)) ? BW'(NB) : in_full[BW-1:0];
    in_opc_ok = (umi_in_cmd[4:0] == OP_REQ_WRITE) ||
                (umi_in_cmd[4:0] == OP_REQ_POSTED) ||
                (umi_in_cmd[4:0] == OP_RESP_READ);
    in_split  = in_opc_ok &&
                ((32'd1 << umi_in_cmd[7:5]) <= 32'(SPLIT_BYTES)) &&
                (32'(in_bytes) > 32'(SPLIT_BYTES));
  end

  // Handshake terms
  logic last_w, accept_w, out_hs_w;

  always_comb begin
    last_w       = (state_q == BUSY) &&
                   (!split_q || (32'(off_q) + 32'(SPLIT_BYTES) >= 32'(bytes_q)));
    umi_in_ready = (state_q == IDLE) || (last_w && umi_out_ready);
    accept_w     = umi_in_valid && umi_in_ready;
    out_hs_w     = out_valid_q && umi_out_ready;
  end

  // Piece builder: piece 0 of a newly accepted flit, or the next piece of
  // the held flit. Sharing one builder keeps a single set of output muxes.
  logic [CW-1:0] p_cmd;
  logic [AW-1:0] p_dst;
  logic [DW-1:0] p_data;
  logic [BW-1:0] p_bytes;
  logic          p_split;
  logic [OW-1:0] p_off;
  logic [BW-1:0] p_rem;
  logic [BW-1:0] p_chunk;
  logic [7:0]    p_len;
  logic          p_last;
  logic [DW-1:0] p_shift;
  logic [CW-1:0] piece_cmd;
  logic [AW-1:0] piece_dst;
  logic [DW-1:0] piece_data;

  always_comb begin
    p_cmd   = accept_w ? umi_in_cmd     : cmd_q;
    p_dst   = accept_w ? umi_in_dstaddr : dst_q;
    p_data  = accept_w ? umi_in_data    : data_q;
    p_bytes = accept_w ? in_bytes       : bytes_q;
    p_split = accept_w ? in_split       : split_q;
    p_off   = accept_w ? '0 : off_q + OW'(SPLIT_BYTES);

    p_rem   = p_bytes - BW'(p_off);
    p_chunk = (32'(p_rem) > 32'(SPLIT_BYTES)) ? BW'(SPLIT_BYTES) : p_rem;
    p_len   = 8'((32'(p_chunk) >> p_cmd[7:5]) - 32'd1);
    p_last  = (32'(p_off) + 32'(SPLIT_BYTES) >= 32'(p_bytes));

    // Bytes beyond the chunk are zeroed so downstream never sees stale data
    p_shift = p_data >> {p_off, 3'b000};
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(p_chunk)) begin
        p_shift[8*i +: 8] = 8'h00;
      end
    end

    piece_cmd  = p_cmd;
    piece_dst  = p_dst;
    piece_data = p_data;
    if (p_split) begin
      piece_cmd[15:8] = p_len;
      piece_cmd[22]   = p_cmd[22] & p_last;
      piece_dst       = p_dst + AW'(p_off);
      piece_data      = p_shift;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    dst_d       = dst_q;
    data_d      = data_q;
    bytes_d     = bytes_q;
    split_d     = split_q;
    off_d       = off_q;
    out_valid_d = out_valid_q;
    out_cmd_d   = out_cmd_q;
    out_dst_d   = out_dst_q;
    out_src_d   = out_src_q;
    out_data_d  = out_data_q;

    if (accept_w) begin
      state_d     = BUSY;
      cmd_d       = umi_in_cmd;
      dst_d       = umi_in_dstaddr;
      data_d      = umi_in_data;
      bytes_d     = in_bytes;
      split_d     = in_split;
      off_d       = '0;
      out_valid_d = 1'b1;
      out_cmd_d   = piece_cmd;
      out_dst_d   = piece_dst;
      out_src_d   = umi_in_srcaddr;
      out_data_d  = piece_data;
    end else if (out_hs_w && !last_w) begin
      off_d       = p_off;
      out_cmd_d   = piece_cmd;
      out_dst_d   = piece_dst;
      out_data_d  = piece_data;
    end else if (out_hs_w) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      bytes_q     <= '0;
      split_q     <= 1'b0;
      off_q       <= '0;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_dst_q   <= '0;
      out_src_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      dst_q       <= dst_d;
      data_q      <= data_d;
      bytes_q     <= bytes_d;
      split_q     <= split_d;
      off_q       <= off_d;
      out_valid_q <= out_valid_d;
      out_cmd_q   <= out_cmd_d;
      out_dst_q   <= out_dst_d;
      out_src_q   <= out_src_d;
      out_data_q  <= out_data_d;
    end
  end

  assign umi_out_valid   = out_valid_q;
  assign umi_out_cmd     = out_cmd_q;
  assign umi_out_dstaddr = out_dst_q;
  assign umi_out_srcaddr = out_src_q;
  assign umi_out_data    = out_data_q;

endmodule
`default_nettype wire

// File: doc/umi_data_splitter.md
UMI_DATA_SPLITTER -- requirements
Module: umi_data_splitter

Interface
REQ-001 SHALL have parameter CW, default 32, meaning command width.
REQ-002 SHALL have parameter AW, default 64, meaning address width.
REQ-003 SHALL have parameter DW, default 64, meaning data width.
REQ-004 SHALL have parameter SPLIT_BYTES, default 4, meaning max bytes per output flit; power of two, 1..DW/8.
REQ-005 SHALL use one clock, clk, and an asynchronous, active-high reset, reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  async active-high reset.
REQ-008 umi_in_valid/umi_in_cmd/umi_in_dstaddr/umi_in_srcaddr/umi_in_data  input  1/CW/AW/AW/DW  input UMI flit.
REQ-009 umi_in_ready  output  1  input flit accepted when valid&&ready.
REQ-010 umi_out_valid/umi_out_cmd/umi_out_dstaddr/umi_out_srcaddr/umi_out_data  output  1/CW/AW/AW/DW  output UMI flit.
REQ-011 umi_out_ready  input  1  downstream accepts when valid&&ready.

Function
REQ-012 Command fields SHALL be decoded and encoded with the standard UMI pack/unpack field layout.
REQ-013 Input flit byte count: bytes = (1<<size)*(len+1), computed in clog2(DW/8)+2 bits; values above DW/8 are clamped to DW/8.
REQ-014 Splittable flit: opcode is write, write-posted or read-response; (1<<size) <= SPLIT_BYTES; bytes > SPLIT_BYTES.
REQ-015 A non-splittable flit SHALL be emitted as one output flit with cmd, addresses and data bit-identical to the input.
REQ-016 A splittable flit SHALL be emitted as N = ceil(bytes/SPLIT_BYTES) flits, in ascending offset order.
REQ-017 Piece k: offset = k*SPLIT_BYTES; chunk = min(SPLIT_BYTES, bytes-offset).
REQ-018 Piece k: len = chunk/(1<<size)-1.
REQ-019 Piece k: dstaddr = in_dstaddr+offset, mod 2^AW; srcaddr unchanged.
REQ-020 Piece k: data = (in_data >> 8*offset), with bytes at index chunk and above forced to zero.
REQ-021 Piece k: eom = in_eom && (k==N-1); opcode, size, atype, qos, prot, eof, ex, user, user_extended, err and hostid are copied unchanged.
REQ-022 State: IDLE (no flit held) and BUSY (flit registered, pieces pending); an offset counter of clog2(DW/8)+1 bits tracks the current piece.
REQ-023 IDLE->BUSY on input handshake; BUSY->IDLE when the last piece handshakes and no new input is accepted in that cycle.
REQ-024 umi_in_ready = IDLE || (last piece && umi_out_ready); this is combinational and allows back-to-back flits without bubbles.
REQ-025 Latency: the first output piece is valid the cycle after input acceptance; each following piece is valid the cycle after the previous handshake.
REQ-026 While umi_out_valid && !umi_out_ready, all umi_out_* SHALL hold stable.
REQ-027 umi_out_valid SHALL never drop without a handshake.
REQ-028 If the last piece handshakes in the same cycle as a new input is accepted, the new flit's piece 0 SHALL be presented next cycle.
REQ-029 Output fields SHALL be registered; no combinational path from umi_in_* to umi_out_*.

Reset
REQ-030 While reset is high: umi_out_valid=0; umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr and umi_out_data=0; state=IDLE; offset=0.
REQ-031 umi_in_ready SHALL be 1 during and after reset.
REQ-032 Reset mid-split SHALL discard the remaining pieces; no partial piece is emitted after reset deasserts.

Verification (DW=64, SPLIT_BYTES=4)
REQ-033 Write, size=0, len=7, dst=0x100, src=0x200, data=0x8877665544332211, eom=1 -> piece 0: len=3, dst=0x100, src=0x200, data=0x44332211, eom=0; piece 1: len=3, dst=0x104, data=0x88776655, eom=1.
REQ-034 Read-response, size=0, len=5, dst=0x40, data=0xFFFF665544332211 -> piece 0: len=3, dst=0x40, data=0x44332211; piece 1: len=1, dst=0x44, data=0x6655.
REQ-035 Write size=0 len=2; read request len=7; write size=3 len=0 -> each emitted as one unchanged flit.
REQ-036 Hold umi_out_ready=0 for 3 cycles during piece 0 of REQ-033 -> piece 0 stable; umi_in_ready=0; piece 1 follows after release.
REQ-037 Two REQ-033 flits back-to-back with umi_out_ready=1 -> 4 pieces on 4 consecutive cycles, no bubble.
REQ-038 Assert reset after piece 0 handshake -> umi_out_valid=0 and umi_in_ready=1; the next flit's output starts at offset 0.
